// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - handshaked instruction fetch with redirect flush and fetch buffer
module fetch_stage #(
    parameter int              PC_W       = 32,
    parameter int              INSTR_W    = 16,
    parameter int              ADDR_W     = 21,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter int              PC_STEP    = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_fetch_en,
    output logic               o_imem_req,
    output logic [ADDR_W-1:0]  o_imem_addr,
    input  logic               i_imem_ack,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    input  logic               i_redirect_valid,
    input  logic [PC_W-1:0]    i_redirect_pc,
    output logic               o_out_valid,
    output logic [INSTR_W-1:0] o_out_instr,
    output logic [PC_W-1:0]    o_out_pc,
    input  logic               i_out_ready
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic {ST_ISSUE, ST_DRAIN} state_t;

    state_t             r_state;
    logic [PC_W-1:0]    r_fpc;
    logic               r_req;
    logic [ADDR_W-1:0]  r_addr;
    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [PC_W-1:0]    r_pc_mem    [FIFO_DEPTH];
    logic [INSTR_W-1:0] r_instr_mem [FIFO_DEPTH];

    logic               w_ack;
    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_count_next;
    logic [PC_W-1:0]    w_fpc_next;
    logic               w_req_next;

    always_comb begin
        w_ack  = r_req & i_imem_ack;
        // Responses landing in DRAIN or alongside a redirect belong to the abandoned stream.
        w_push = w_ack & (r_state == ST_ISSUE) & ~i_redirect_valid;
        w_pop  = o_out_valid & i_out_ready & ~i_redirect_valid;

        w_count_next = r_count;
        if (i_redirect_valid) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - CNT_W'(1);
        end

        w_fpc_next = r_fpc;
        if (i_redirect_valid) begin
            w_fpc_next = i_redirect_pc;
        end else if (w_push) begin
            w_fpc_next = r_fpc + PC_W'(PC_STEP);
        end

        // A pending request is held until acked; a new one needs a free slot after this cycle.
        w_req_next = (r_req & ~i_imem_ack) | (i_fetch_en & (w_count_next < DEPTH_C));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_ISSUE;
            r_fpc   <= RESET_PC;
            r_req   <= 1'b0;
            r_addr  <= RESET_PC[ADDR_W-1:0];
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            r_fpc   <= w_fpc_next;
            r_req   <= w_req_next;
            r_count <= w_count_next;
            if (!r_req || i_imem_ack) begin
                r_addr <= w_fpc_next[ADDR_W-1:0];
            end
            if (i_redirect_valid) begin
                r_state <= (r_req && !i_imem_ack) ? ST_DRAIN : ST_ISSUE;
                r_wptr  <= '0;
                r_rptr  <= '0;
            end else begin
                if (r_state == ST_DRAIN && w_ack) begin
                    r_state <= ST_ISSUE;
                end
                if (w_push) begin
                    r_wptr <= r_wptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_pc_mem[r_wptr]    <= r_fpc;
            r_instr_mem[r_wptr] <= i_imem_rdata;
        end
    end

    always_comb begin
        o_imem_req  = r_req;
        o_imem_addr = r_addr;
        o_out_valid = (r_count != '0);
        o_out_pc    = o_out_valid ? r_pc_mem[r_rptr]    : '0;
        o_out_instr = o_out_valid ? r_instr_mem[r_rptr] : '0;
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with random memory latency
module tb_fetch_stage;
    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic        imem_req;
    logic [20:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;

    logic        wrap_req;
    logic [20:0] wrap_addr;
    logic        wrap_valid;
    logic [15:0] wrap_instr;
    logic [31:0] wrap_pc;

    int checks   = 0;
    int failures = 0;
    int n_xfers  = 0;
    int lat_min  = 0;
    int lat_max  = 0;
    int lat_left = 0;
    bit mon_en   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] next_fill;

    fetch_stage #(.PC_W(32), .INSTR_W(16), .ADDR_W(21), .FIFO_DEPTH(4),
                  .RESET_PC(32'h0), .PC_STEP(1)) dut (
        .i_clk(clk), .i_reset(reset), .i_fetch_en(fetch_en),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr),
        .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata),
        .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc),
        .o_out_valid(out_valid), .o_out_instr(out_instr), .o_out_pc(out_pc),
        .i_out_ready(out_ready)
    );

    fetch_stage #(.PC_W(32), .INSTR_W(16), .ADDR_W(21), .FIFO_DEPTH(4),
                  .RESET_PC(32'hFFFF_FFFF), .PC_STEP(1)) dut_wrap (
        .i_clk(clk), .i_reset(reset), .i_fetch_en(1'b1),
        .o_imem_req(wrap_req), .o_imem_addr(wrap_addr),
        .i_imem_ack(1'b1), .i_imem_rdata(16'h1234),
        .i_redirect_valid(1'b0), .i_redirect_pc(32'h0),
        .o_out_valid(wrap_valid), .o_out_instr(wrap_instr), .o_out_pc(wrap_pc),
        .i_out_ready(1'b1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] mem_word(input logic [20:0] a);
        return a[15:0] ^ {a[20:16], 11'h5A3};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decode should see an unbroken run of consecutive PCs from the last restart point.
    task automatic sb_restart(input logic [31:0] start);
        exp_q.delete();
        next_fill = start;
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(next_fill);
            next_fill = next_fill + 32'd1;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        redirect_valid = 1'b0;
        sb_restart(32'h0);
        repeat (n) cyc();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) got = 1'b1;
        end
        chk(name, {63'd0, got}, 64'd1);
    endtask

    // Memory responder: random wait states between lat_min and lat_max per request.
    initial begin
        imem_ack = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (imem_req !== 1'b1) begin
                imem_ack = 1'b0;
                lat_left = $urandom_range(lat_max, lat_min);
            end else if (lat_left == 0) begin
                imem_ack = 1'b1;
                imem_rdata = mem_word(imem_addr);
                lat_left = $urandom_range(lat_max, lat_min);
            end else begin
                imem_ack = 1'b0;
                imem_rdata = $urandom;
                lat_left--;
            end
        end
    end

    // Monitor: scoreboard pops on each accepted transfer plus request-stability checks.
    initial begin
        logic        prev_pend;
        logic [20:0] prev_addr;
        logic        prev_reset;
        logic [31:0] exp_pc;
        prev_pend = 1'b0;
        prev_addr = '0;
        prev_reset = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (!reset && !prev_reset && prev_pend) begin
                    chk("req_held", {63'd0, imem_req}, 64'd1);
                    chk("addr_held", {43'd0, imem_addr}, {43'd0, prev_addr});
                end
                if (out_valid === 1'b0) begin
                    chk("empty_zero", {16'd0, out_pc, out_instr}, 64'd0);
                end
                if (!reset && out_valid === 1'b1 && out_ready && !redirect_valid) begin
                    n_xfers++;
                    if (exp_q.size() == 0) begin
                        chk("sb_underflow", 64'd1, 64'd0);
                    end else begin
                        exp_pc = exp_q.pop_front();
                        chk("out_pc", {32'd0, out_pc}, {32'd0, exp_pc});
                        chk("out_instr", {48'd0, out_instr}, {48'd0, mem_word(exp_pc[20:0])});
                    end
                    if (exp_q.size() < 32) begin
                        for (int i = 0; i < 32; i++) begin
                            exp_q.push_back(next_fill);
                            next_fill = next_fill + 32'd1;
                        end
                    end
                end
            end
            prev_pend  = imem_req & ~imem_ack;
            prev_addr  = imem_addr;
            prev_reset = reset;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [31:0] rpc;
        reset = 1'b1;
        fetch_en = 1'b1;
        out_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        sb_restart(32'h0);

        // Zero-wait streaming, first-valid latency, reset values, PC wrap instance.
        cyc();
        do_reset(2);
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_req", {63'd0, imem_req}, 64'd0);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_addr", {43'd0, imem_addr}, 64'd0);
        chk("wrap_rst_addr", {43'd0, wrap_addr}, {43'd0, 21'h1F_FFFF});
        @(negedge clk);
        chk("lat_valid_e1", {63'd0, out_valid}, 64'd0);
        chk("lat_req_e1", {63'd0, imem_req}, 64'd1);
        @(negedge clk);
        chk("lat_valid_e2", {63'd0, out_valid}, 64'd1);
        chk("first_pc", {32'd0, out_pc}, 64'd0);
        chk("wrap_valid", {63'd0, wrap_valid}, 64'd1);
        chk("wrap_pc0", {32'd0, wrap_pc}, 64'hFFFF_FFFF);
        chk("wrap_instr", {48'd0, wrap_instr}, 64'h1234);
        @(negedge clk);
        chk("wrap_pc1", {32'd0, wrap_pc}, 64'h0);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid === 1'b1) n++;
        end
        chk("back_to_back", n, 20);

        // Stall: exactly FIFO_DEPTH entries buffered, then resume at pc 4.
        cyc();
        out_ready = 1'b0;
        do_reset(2);
        repeat (12) cyc();
        @(negedge clk);
        chk("stall_req", {63'd0, imem_req}, 64'd0);
        chk("stall_head", {32'd0, out_pc}, 64'd0);
        cyc();
        fetch_en = 1'b0;
        out_ready = 1'b1;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid === 1'b1) n++;
        end
        chk("stall_depth", n, 4);
        cyc();
        fetch_en = 1'b1;
        wait_valid("resume_valid");
        chk("resume_pc", {32'd0, out_pc}, 64'd4);

        // Redirect while a 3-cycle request is pending.
        cyc();
        lat_min = 3;
        lat_max = 3;
        do_reset(2);
        cyc();
        chk("drain_setup", {62'd0, imem_req, imem_ack}, 64'b10);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        sb_restart(32'h40);
        cyc();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("drain_addr", {43'd0, imem_addr}, 64'd0);
        wait_valid("drain_valid");
        chk("drain_pc", {32'd0, out_pc}, 64'h40);

        // Redirect coinciding with ack and pop, two entries buffered.
        cyc();
        lat_min = 0;
        lat_max = 0;
        out_ready = 1'b0;
        do_reset(2);
        cyc();
        cyc();
        cyc();
        chk("same_setup", {62'd0, imem_ack, out_valid}, 64'b11);
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        sb_restart(32'h100);
        cyc();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("same_flush", {63'd0, out_valid}, 64'd0);
        wait_valid("same_valid");
        chk("same_pc", {32'd0, out_pc}, 64'h100);

        // Reset while a request is pending with data buffered.
        cyc();
        lat_min = 1;
        lat_max = 1;
        do_reset(2);
        cyc();
        cyc();
        cyc();
        chk("rstp_setup", {61'd0, imem_req, imem_ack, out_valid}, 64'b101);
        reset = 1'b1;
        sb_restart(32'h0);
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("rstp_req", {63'd0, imem_req}, 64'd0);
        chk("rstp_valid", {63'd0, out_valid}, 64'd0);
        chk("rstp_addr", {43'd0, imem_addr}, 64'd0);
        wait_valid("rstp_resume");
        chk("rstp_pc", {32'd0, out_pc}, 64'd0);

        // Random traffic against the scoreboard.
        cyc();
        lat_min = 0;
        lat_max = 3;
        do_reset(2);
        n_xfers = 0;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            fetch_en  = ($urandom_range(7, 0) != 0);
            out_ready = ($urandom_range(3, 0) != 0);
            if ($urandom_range(399, 0) == 0) begin
                do_reset(2);
            end else if ($urandom_range(31, 0) == 0) begin
                rpc = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFE : $urandom;
                redirect_valid = 1'b1;
                redirect_pc = rpc;
                sb_restart(rpc);
            end else begin
                redirect_valid = 1'b0;
            end
        end
        cyc();
        redirect_valid = 1'b0;
        chk("random_progress", {63'd0, n_xfers >= 500}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
